// File: rtl/baccarat_sequencer.sv
// Purpose: game-control FSM for the baccarat datapath; sequences card loads, applies third-card rules, drives win lights.
// Latency: one state per slow_clock edge; loads, lights and state_code are registered with the state (pure state decode).
// Backpressure: none; the FSM advances on every edge and DONE holds until resetb is asserted.
module baccarat_sequencer #(
    parameter int unsigned NATURAL_MIN     = 8,
    parameter int unsigned PLAYER_DRAW_MAX = 5
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic [3:0] state_code
);

    typedef enum logic [3:0] {
        DEAL_P1  = 4'd0,
        DEAL_D1  = 4'd1,
        DEAL_P2  = 4'd2,
        DEAL_D2  = 4'd3,
        CHECK    = 4'd4,
        DEAL_P3  = 4'd5,
        BANK_CHK = 4'd6,
        DEAL_D3  = 4'd7,
        DONE     = 4'd8
    } state_t;

    localparam logic [3:0] NAT_MIN  = 4'(NATURAL_MIN);
    localparam logic [3:0] PDRAW_MX = 4'(PLAYER_DRAW_MAX);

    state_t r_state;
    state_t w_next;
    logic   w_bank_draw;
    logic   r_load_pcard1, r_load_pcard2, r_load_pcard3;
    logic   r_load_dcard1, r_load_dcard2, r_load_dcard3;
    logic   r_player_win, r_dealer_win;

    // Banker third-card rule after the player has drawn, indexed by banker score
    always_comb begin
        w_bank_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: w_bank_draw = 1'b1;
            4'd3:             w_bank_draw = (pcard3 != 4'd8);
            4'd4:             w_bank_draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:             w_bank_draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:             w_bank_draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
            default:          w_bank_draw = 1'b0;
        endcase
    end

    // Next-state selection; unused codes recover to the first deal state
    always_comb begin
        w_next = DEAL_P1;
        case (r_state)
            DEAL_P1:  w_next = DEAL_D1;
            DEAL_D1:  w_next = DEAL_P2;
            DEAL_P2:  w_next = DEAL_D2;
            DEAL_D2:  w_next = CHECK;
            CHECK: begin
                if ((pscore >= NAT_MIN) || (dscore >= NAT_MIN)) w_next = DONE;
                else if (pscore <= PDRAW_MX)                    w_next = DEAL_P3;
                else if (dscore <= 4'd5)                        w_next = DEAL_D3;
                else                                            w_next = DONE;
            end
            DEAL_P3:  w_next = BANK_CHK;
            BANK_CHK: w_next = w_bank_draw ? DEAL_D3 : DONE;
            DEAL_D3:  w_next = DONE;
            DONE:     w_next = DONE;
            default:  w_next = DEAL_P1;
        endcase
    end

    // State register with outputs registered from the state being entered
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            r_state       <= DEAL_P1;
            r_load_pcard1 <= 1'b1;
            r_load_pcard2 <= 1'b0;
            r_load_pcard3 <= 1'b0;
            r_load_dcard1 <= 1'b0;
            r_load_dcard2 <= 1'b0;
            r_load_dcard3 <= 1'b0;
            r_player_win  <= 1'b0;
            r_dealer_win  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_load_pcard1 <= (w_next == DEAL_P1);
            r_load_pcard2 <= (w_next == DEAL_P2);
            r_load_pcard3 <= (w_next == DEAL_P3);
            r_load_dcard1 <= (w_next == DEAL_D1);
            r_load_dcard2 <= (w_next == DEAL_D2);
            r_load_dcard3 <= (w_next == DEAL_D3);
            r_player_win  <= (w_next == DONE) && (pscore >= dscore);
            r_dealer_win  <= (w_next == DONE) && (dscore >= pscore);
        end
    end

    assign load_pcard1      = r_load_pcard1;
    assign load_pcard2      = r_load_pcard2;
    assign load_pcard3      = r_load_pcard3;
    assign load_dcard1      = r_load_dcard1;
    assign load_dcard2      = r_load_dcard2;
    assign load_dcard3      = r_load_dcard3;
    assign player_win_light = r_player_win;
    assign dealer_win_light = r_dealer_win;
    assign state_code       = r_state;

endmodule

// File: tb/tb_baccarat_sequencer.sv
module tb_baccarat_sequencer;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic [3:0] pscore     = 4'd0;
    logic [3:0] dscore     = 4'd0;
    logic [3:0] pcard3     = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
    logic [3:0] state_code;

    int n_total = 0;
    int n_pass  = 0;

    baccarat_sequencer dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .state_code       (state_code)
    );

    always #5 slow_clock = ~slow_clock;

    // Loads packed as {p1,p2,p3,d1,d2,d3}
    function automatic logic [5:0] loads();
        return {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3};
    endfunction

    function automatic logic [1:0] lights();
        return {player_win_light, dealer_win_light};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge slow_clock);
        #1;
    endtask

    // Reference rules: banker draw table as bitmasks over the player's third card
    function automatic bit model_bank(input int d, input int c3);
        logic [9:0] m [10];
        logic [9:0] row;
        m = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC, 10'h0F0, 10'h0C0, 10'h000, 10'h000, 10'h000};
        row = m[d];
        return row[c3];
    endfunction

    task automatic model(input int p, input int d, input int c3, output bit p3, output bit d3);
        bit natural;
        natural = (p >= 8) || (d >= 8);
        p3 = !natural && (p <= 5);
        if (natural)  d3 = 1'b0;
        else if (p3)  d3 = model_bank(d, c3);
        else          d3 = (d <= 5);
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        step();
        resetb = 1'b1;
    endtask

    // Walk the fixed deal sequence from DEAL_P1 to CHECK
    task automatic deal_four(input string tag);
        logic [5:0] exp_ld [4];
        exp_ld = '{6'b100000, 6'b000100, 6'b010000, 6'b000010};
        for (int i = 0; i < 4; i++) begin
            chk({tag, " deal state"}, int'(state_code), i);
            chk({tag, " deal load"}, int'(loads()), int'(exp_ld[i]));
            step();
        end
        chk({tag, " check state"}, int'(state_code), 4);
        chk({tag, " check loads"}, int'(loads()), 0);
    endtask

    task automatic play(input int p, input int d, input int c3, input int fp, input int fd,
                        input bit ep3, input bit ed3, input bit epw, input bit edw, input string tag);
        bit saw_p3, saw_d3;
        int n;
        pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
        do_reset();
        deal_four(tag);
        pscore = 4'(p); dscore = 4'(d); pcard3 = 4'(c3);
        saw_p3 = 0; saw_d3 = 0;
        step();
        n = 1;
        while (state_code != 4'd8 && n < 6) begin
            if (load_pcard3) saw_p3 = 1;
            if (load_dcard3) saw_d3 = 1;
            case (state_code)
                4'd5:    chk({tag, " p3 loads"}, int'(loads()), 6'b001000);
                4'd7:    chk({tag, " d3 loads"}, int'(loads()), 6'b000001);
                default: chk({tag, " mid loads"}, int'(loads()), 0);
            endcase
            chk({tag, " mid lights"}, int'(lights()), 0);
            step();
            n++;
        end
        chk({tag, " reached done"}, int'(state_code), 8);
        chk({tag, " player drew"}, int'(saw_p3), int'(ep3));
        chk({tag, " banker drew"}, int'(saw_d3), int'(ed3));
        chk({tag, " edges to done"}, n, 1 + 2 * int'(ep3) + int'(ed3));
        chk({tag, " done loads"}, int'(loads()), 0);
        chk({tag, " entry lights"}, int'(lights()), int'({p >= d, d >= p}));
        pscore = 4'(fp); dscore = 4'(fd);
        step();
        chk({tag, " final lights"}, int'(lights()), int'({epw, edw}));
        step();
        chk({tag, " done holds"}, int'(state_code), 8);
    endtask

    typedef struct {
        int p, d, c3, fp, fd;
        bit ep3, ed3, epw, edw;
    } vec_t;

    initial begin
        vec_t vt [10];
        bit mp3, md3;
        int p, d, c3, fp, fd;

        vt = '{
            '{8, 3, 0, 8, 3, 0, 0, 1, 0},
            '{4, 5, 4, 8, 8, 1, 1, 1, 1},
            '{6, 5, 0, 6, 7, 0, 1, 0, 1},
            '{2, 3, 8, 2, 3, 1, 0, 0, 1},
            '{2, 6, 5, 5, 6, 1, 0, 0, 1},
            '{7, 9, 0, 7, 9, 0, 0, 0, 1},
            '{7, 7, 0, 7, 7, 0, 0, 1, 1},
            '{0, 2, 0, 3, 1, 1, 1, 1, 0},
            '{5, 4, 1, 6, 4, 1, 0, 1, 0},
            '{6, 6, 0, 6, 6, 0, 0, 1, 1}
        };

        // Reset state
        do_reset();
        chk("reset state", int'(state_code), 0);
        chk("reset loads", int'(loads()), 6'b100000);
        chk("reset lights", int'(lights()), 0);

        // Table-driven games
        for (int i = 0; i < 10; i++)
            play(vt[i].p, vt[i].d, vt[i].c3, vt[i].fp, vt[i].fd,
                 vt[i].ep3, vt[i].ed3, vt[i].epw, vt[i].edw, $sformatf("vec%0d", i));

        // Reset out of DEAL_D3 (state 7)
        do_reset();
        deal_four("rst7");
        pscore = 4'd6; dscore = 4'd5;
        step();
        chk("rst7 in d3", int'(state_code), 7);
        resetb = 1'b0;
        step();
        resetb = 1'b1;
        chk("rst7 state", int'(state_code), 0);
        chk("rst7 loads", int'(loads()), 6'b100000);
        chk("rst7 lights", int'(lights()), 0);

        // Reset held while in BANK_CHK
        do_reset();
        deal_four("rst6");
        pscore = 4'd2; dscore = 4'd3; pcard3 = 4'd4;
        step();
        step();
        chk("rst6 in bank", int'(state_code), 6);
        resetb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst6 held state", int'(state_code), 0);
            chk("rst6 held loads", int'(loads()), 6'b100000);
        end
        resetb = 1'b1;
        step();
        chk("rst6 release", int'(state_code), 1);

        // Randomized games against the rules model
        for (int i = 0; i < 40; i++) begin
            p  = int'($urandom_range(9, 0));
            d  = int'($urandom_range(9, 0));
            c3 = int'($urandom_range(9, 0));
            fp = int'($urandom_range(9, 0));
            fd = int'($urandom_range(9, 0));
            model(p, d, c3, mp3, md3);
            play(p, d, c3, fp, fd, mp3, md3, fp >= fd, fd >= fp, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
